mem_arbiter: RTL
================

# mem_arbiter

Two-master arbiter for the single shared memory port (Memread / Memwrite / Addr / data bus). Master 0 is the CPU; master 1 is a second bus master (DMA or display fetch). Each accepted access is issued for exactly one cycle. Reads wait a fixed latency, then return data to the owning master. Back-to-back contention is resolved round-robin.

## Interface
- Parameters:
  - RD_LAT, 1, cycles from the mem_read cycle to valid mem_rdata (legal 1..7)
- Ports:
  - clk  in  1  clock, rising edge
  - rst  in  1  reset, asynchronous, active-high
  - m0_req, m1_req  in  1  access request; held with its qualifiers until gnt
  - m0_we, m1_we  in  2  0 = read, 1 = word write, 3 = byte write, 2 reserved (forwarded unchanged)
  - m0_addr, m1_addr  in  32  byte address
  - m0_wdata, m1_wdata  in  32  write data
  - m0_gnt, m1_gnt  out  1  one-cycle pulse; the access is on the memory port this cycle
  - m0_done, m1_done  out  1  one-cycle pulse; write retired or read data valid
  - m0_rdata, m1_rdata  out  32  read data; stable from done until that master's next read completes
  - mem_read  out  1  memory read strobe
  - mem_write  out  2  memory write code (copy of granted we)
  - mem_addr  out  32  memory address
  - mem_wdata  out  32  memory write data
  - mem_rdata  in  32  memory read data

## Operation
- States:
  - IDLE: arbitration allowed.
  - ISSUE: mem_* driven for one cycle.
  - RWAIT: read latency countdown.
- Arbitration at each edge in IDLE, or at the end of an ISSUE/RWAIT that returns to IDLE:
  - Eligible = req high and not currently granted. The master whose gnt is high this cycle is masked at that edge.
  - One eligible master wins outright.
  - Two eligible: the master not granted last wins. The `last` register resets to 1, so m0 wins first contention.
- On win, at the next edge:
  - Register addr/wdata/we.
  - Drive gnt, plus mem_read (we = 0) or mem_write = we.
  - Update `last`.
  - Enter ISSUE.
- ISSUE, write: done pulses in the same cycle as gnt. Next state is IDLE, or directly ISSUE again if a new winner exists.
- ISSUE, read: load cnt = RD_LAT and go to RWAIT. mem_* return to 0.
- RWAIT:
  - Decrement cnt each edge.
  - At the edge ending the cycle where cnt = 1: capture mem_rdata into the owner's rdata and pulse its done in the following cycle.
  - That same edge is an arbitration point, so a new ISSUE may coincide with the done cycle.
- No new access is issued while a read is outstanding.
- mem_read and mem_write are never both nonzero. Outside ISSUE, all mem_* outputs are 0.

## Timing
- Reset values: all gnt/done 0, rdata 0, mem_read 0, mem_write 0, mem_addr 0, mem_wdata 0, state IDLE, last 1, cnt 0.
- Request latency: req high before edge E means gnt and the mem strobe are high in cycle E+1.
- Write: done in E+1. Back-to-back writes issue every cycle.
- Read: done and rdata valid in cycle E+1+RD_LAT+1. Minimum spacing between read issues is RD_LAT+1 cycles.
- A requester must drop req or change qualifiers only after seeing gnt. Holding req through gnt is safe (masking), but a req still high one cycle later counts as a new request.
- rst asserted mid-operation: outputs clear immediately; an outstanding read is abandoned with no done. After release, the first edge is treated as IDLE.
- RD_LAT outside 1..7 is unsupported; the 3-bit counter covers the legal range.

## Structure
- Shared package `mem_bus_pkg`:
  - WE_RD = 2'b00, WE_WORD = 2'b01, WE_BYTE = 2'b11
  - state encoding ST_IDLE, ST_ISSUE, ST_RWAIT
- Sub-module `rr_pick2`: combinational two-way round-robin pick (inputs req0, req1, last; outputs win_valid, win_id).

## Test plan
- m0 word write alone:
  - Stimulus: addr 0x10, data 0xDEADBEEF.
  - Response: one cycle later m0_gnt = m0_done = 1, mem_write = 1, mem_addr = 0x10, mem_wdata = 0xDEADBEEF. Both masters see no other activity.
- m1 read with RD_LAT = 2:
  - Stimulus: mem_rdata = 0x1234 in the cycle 2 after mem_read.
  - Response: m1_done high in the following cycle, m1_rdata = 0x1234 held afterwards.
- m0 and m1 request together, repeated 4 times:
  - Response: grant order m0, m1, m0, m1; never both gnt in the same cycle.
- Read pending while m0 requests a write:
  - Response: the write is not issued until the read's done cycle; mem_read and mem_write are never both active.
- rst pulsed during RWAIT:
  - Response: no done pulse; all outputs 0 immediately.
  - After release, m0 and m1 requesting together: m0 is granted first.
- m0 byte write (we = 3) held through gnt:
  - Response: mem_write = 3 for exactly one cycle; no duplicate grant.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared memory-bus encodings and arbiter state type
//   WE_RD / WE_WORD / WE_BYTE : memory write codes carried on *_we and mem_write
//   state_t                   : arbiter FSM state encoding
//   is_write()                : true for any non-read code, the reserved code included
package mem_bus_pkg;

    localparam logic [1:0] WE_RD   = 2'b00;
    localparam logic [1:0] WE_WORD = 2'b01;
    localparam logic [1:0] WE_BYTE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RWAIT
    } state_t;

    function automatic logic is_write(input logic [1:0] we);
        return we != WE_RD;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational two-way round-robin pick
//   req0, req1 : eligible requests
//   last       : id of the master granted most recently
//   win_valid  : some request is eligible
//   win_id     : winning master id (the one not granted last on a tie)
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic win_valid,
    output logic win_id
);

    assign win_valid = req0 || req1;
    assign win_id    = (req0 && req1) ? !last : req1;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master round-robin arbiter for the shared memory port
//   clk, rst                    : clock, asynchronous active-high reset
//   m*_req/we/addr/wdata        : master requests with qualifiers, held until gnt
//   m*_gnt                      : access is on the memory port this cycle
//   m*_done                     : write retired or read data valid
//   m*_rdata                    : last read data returned to that master
//   mem_read/write/addr/wdata   : memory port, all zero outside an issue cycle
//   mem_rdata                   : memory read data, sampled RD_LAT cycles after mem_read
module mem_arbiter
    import mem_bus_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic [1:0]  m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m1_req,
    input  logic [1:0]  m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic        m0_done,
    output logic        m1_done,
    output logic [31:0] m0_rdata,
    output logic [31:0] m1_rdata,
    output logic        mem_read,
    output logic [1:0]  mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic        r_last;
    logic        r_owner;
    logic [1:0]  r_gnt;
    logic [1:0]  r_done;
    logic [31:0] r_rdata0;
    logic [31:0] r_rdata1;
    logic        r_mem_read;
    logic [1:0]  r_mem_write;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;

    logic        w_arb;
    logic        w_win;
    logic        w_id;
    logic [1:0]  w_we;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;

    // Arbitration happens in IDLE, after a write issue, and on the edge that
    // retires a read; a read issue never arbitrates so its latency is exclusive.
    assign w_arb = (r_state == ST_IDLE) ||
                   (r_state == ST_ISSUE && !r_mem_read) ||
                   (r_state == ST_RWAIT && r_cnt == 3'd1);

    // A master granted this cycle is masked so a req held through gnt is not re-issued.
    rr_pick2 u_pick (
        .req0      (m0_req && !r_gnt[0]),
        .req1      (m1_req && !r_gnt[1]),
        .last      (r_last),
        .win_valid (w_win),
        .win_id    (w_id)
    );

    assign w_we    = w_id ? m1_we    : m0_we;
    assign w_addr  = w_id ? m1_addr  : m0_addr;
    assign w_wdata = w_id ? m1_wdata : m0_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 3'd0;
            r_last      <= 1'b1;
            r_owner     <= 1'b0;
            r_gnt       <= 2'b00;
            r_done      <= 2'b00;
            r_rdata0    <= 32'd0;
            r_rdata1    <= 32'd0;
            r_mem_read  <= 1'b0;
            r_mem_write <= WE_RD;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
        end else begin
            r_gnt       <= 2'b00;
            r_done      <= 2'b00;
            r_mem_read  <= 1'b0;
            r_mem_write <= WE_RD;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            if (r_state == ST_RWAIT) begin
                r_cnt <= r_cnt - 3'd1;
                if (r_cnt == 3'd1) begin
                    if (r_owner)
                        r_rdata1 <= mem_rdata;
                    else
                        r_rdata0 <= mem_rdata;
                    r_done[r_owner] <= 1'b1;
                end
            end
            if (r_state == ST_ISSUE && r_mem_read) begin
                r_state <= ST_RWAIT;
                r_cnt   <= 3'(RD_LAT);
            end else if (w_arb && w_win) begin
                r_state     <= ST_ISSUE;
                r_owner     <= w_id;
                r_last      <= w_id;
                r_gnt[w_id] <= 1'b1;
                r_mem_read  <= !is_write(w_we);
                r_mem_write <= w_we;
                r_mem_addr  <= w_addr;
                r_mem_wdata <= w_wdata;
                // Writes retire in their issue cycle; a read's done comes later.
                if (is_write(w_we))
                    r_done[w_id] <= 1'b1;
            end else if (w_arb) begin
                r_state <= ST_IDLE;
            end
        end
    end

    assign m0_gnt    = r_gnt[0];
    assign m1_gnt    = r_gnt[1];
    assign m0_done   = r_done[0];
    assign m1_done   = r_done[1];
    assign m0_rdata  = r_rdata0;
    assign m1_rdata  = r_rdata1;
    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule
